gate_bist_ctrl: RTL and testbench

Self-checking sequencer for the three-input gate datapath (AND/OR/NAND/NOR of a, b, c). On a start request it drives all eight input combinations onto the datapath in ascending order. For each combination it waits a programmable settle time, then compares the four gate outputs against internally computed expected values. It accumulates an error count, the first failing vector and a sticky failing-output mask, then reports pass/fail with a one-cycle done pulse.

---
 rtl/gate_bist_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl
// Purpose  : BIST sequencer that sweeps all eight {a,b,c} vectors through the
//            AND/OR/NAND/NOR datapath and accumulates pass/fail results.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] VEC_LAST = 3'd7;
    localparam logic [3:0] ERR_MAX  = 4'd8;

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic [3:0] fail_mask_q, fail_mask_d;

    logic       exp_and;
    logic       exp_or;
    logic [3:0] expected;
    logic [3:0] mismatch;

    // The stimulus register doubles as the vector index, so expected values
    // always track exactly what the datapath is being driven with.
    always_comb begin
        exp_and  = &vec_q;
        exp_or   = |vec_q;
        expected = {exp_and, exp_or, ~exp_and, ~exp_or};
        mismatch = {d, e, f, g} ^ expected;
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        fail_mask_d  = fail_mask_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SETTLE;
                    vec_d        = 3'd0;
                    cnt_d        = CNT_LOAD;
                    pass_d       = 1'b0;
                    err_cnt_d    = 4'd0;
                    first_fail_d = 3'd0;
                    fail_mask_d  = 4'd0;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = 3'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            CHECK: begin
                if (abort) begin
                    // Abort wins: this cycle's comparison is discarded.
                    state_d = IDLE;
                    vec_d   = 3'd0;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch != 4'd0) begin
                        if (err_cnt_q == 4'd0) begin
                            first_fail_d = vec_q;
                        end
                        if (err_cnt_q < ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                        fail_mask_d = fail_mask_q | mismatch;
                    end
                    if (vec_q != VEC_LAST) begin
                        state_d = SETTLE;
                        vec_d   = vec_q + 3'd1;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = DONE;
                        pass_d  = (err_cnt_d == 4'd0);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                vec_d   = 3'd0;
            end

            default: begin
                state_d = IDLE;
                vec_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            cnt_q        <= 4'd0;
            pass_q       <= 1'b0;
            err_cnt_q    <= 4'd0;
            first_fail_q <= 3'd0;
            fail_mask_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            fail_mask_q  <= fail_mask_d;
        end
    end

    assign {a, b, c}  = vec_q;
    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign first_fail = first_fail_q;
    assign fail_mask  = fail_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_ctrl
// Purpose  : Directed self-checking bench for gate_bist_ctrl (SETTLE_CYC=1,3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0;
    logic start3 = 1'b0, abort3 = 1'b0;
    logic fault_and0 = 1'b0, fault_nor1 = 1'b0;
    logic sel = 1'b0;

    logic a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
    logic [3:0] err1, mask1;
    logic [2:0] ff1;
    logic a3, b3, c3, d3, e3, f3, g3, busy3, done3, pass3;
    logic [3:0] err3, mask3;
    logic [2:0] ff3;

    logic [2:0] o_abc, o_ff;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_err, o_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural gate datapaths with injectable stuck-at faults
    assign d1 = fault_and0 ? 1'b0 : (a1 & b1 & c1);
    assign e1 = a1 | b1 | c1;
    assign f1 = ~(a1 & b1 & c1);
    assign g1 = fault_nor1 ? 1'b1 : ~(a1 | b1 | c1);
    assign d3 = fault_and0 ? 1'b0 : (a3 & b3 & c3);
    assign e3 = a3 | b3 | c3;
    assign f3 = ~(a3 & b3 & c3);
    assign g3 = fault_nor1 ? 1'b1 : ~(a3 | b3 | c3);

    gate_bist_ctrl #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .fail_mask(mask1)
    );

    gate_bist_ctrl #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3), .g(g3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_fail(ff3), .fail_mask(mask3)
    );

    always_comb begin
        if (sel) begin
            o_abc = {a3, b3, c3}; o_busy = busy3; o_done = done3; o_pass = pass3;
            o_err = err3; o_ff = ff3; o_mask = mask3;
        end else begin
            o_abc = {a1, b1, c1}; o_busy = busy1; o_done = done1; o_pass = pass1;
            o_err = err1; o_ff = ff1; o_mask = mask1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; on return we sit just after E0.
    task automatic start_pulse(input bit use3);
        sel = use3;
        step();
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_abc"},  o_abc,  0);
        check_val({tag, "_busy"}, o_busy, 0);
        check_val({tag, "_done"}, o_done, 0);
        check_val({tag, "_pass"}, o_pass, 0);
        check_val({tag, "_err"},  o_err,  0);
        check_val({tag, "_ff"},   o_ff,   0);
        check_val({tag, "_mask"}, o_mask, 0);
    endtask

    task automatic run_seq(input bit use3, input int sc, input bit mid_start,
                           input logic exp_pass, input logic [3:0] exp_cnt,
                           input logic [2:0] exp_ff, input logic [3:0] exp_mask);
        int per;
        per = sc + 1;
        start_pulse(use3);
        for (int n = 0; n < 8 * per; n++) begin
            if (n > 0) step();
            check_val("run_abc",  o_abc,  n / per);
            check_val("run_busy", o_busy, 1);
            check_val("run_done", o_done, 0);
            if (mid_start) start3 = (n == 10);
        end
        step();
        check_val("done_pulse", o_done, 1);
        check_val("done_busy",  o_busy, 0);
        check_val("done_pass",  o_pass, exp_pass);
        check_val("done_err",   o_err,  exp_cnt);
        check_val("done_ff",    o_ff,   exp_ff);
        check_val("done_mask",  o_mask, exp_mask);
        step();
        check_val("post_done", o_done, 0);
        check_val("post_abc",  o_abc,  0);
        check_val("post_pass", o_pass, exp_pass);
        check_val("post_err",  o_err,  exp_cnt);
        for (int i = 0; i < 2 * per; i++) begin
            step();
            check_val("idle_done", o_done, 0);
            check_val("idle_busy", o_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        sel = 1'b0; check_reset_vals("rst1");
        sel = 1'b1; check_reset_vals("rst3");
        rst_n = 1'b1;
        step();

        // Fault-free, SETTLE_CYC=1
        run_seq(1'b0, 1, 1'b0, 1'b1, 4'd0, 3'd0, 4'b0000);

        // AND stuck at 0: only 111 fails
        fault_and0 = 1'b1;
        run_seq(1'b0, 1, 1'b0, 1'b0, 4'd1, 3'd7, 4'b1000);
        fault_and0 = 1'b0;

        // NOR stuck at 1: 001..111 fail
        fault_nor1 = 1'b1;
        run_seq(1'b0, 1, 1'b0, 1'b0, 4'd7, 3'd1, 4'b0001);
        fault_nor1 = 1'b0;

        // SETTLE_CYC=3 fault-free, with an ignored second start mid-run
        run_seq(1'b1, 3, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000);

        // Abort during vector 3 with AND stuck at 0
        fault_and0 = 1'b1;
        start_pulse(1'b0);
        for (int n = 1; n <= 6; n++) step();
        check_val("abort_pre_abc", o_abc, 3);
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check_val("abort_busy", o_busy, 0);
        check_val("abort_abc",  o_abc,  0);
        check_val("abort_done", o_done, 0);
        check_val("abort_pass", o_pass, 0);
        check_val("abort_err",  o_err,  0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("abort_nodone", o_done, 0);
        end
        run_seq(1'b0, 1, 1'b0, 1'b0, 4'd1, 3'd7, 4'b1000);
        fault_and0 = 1'b0;

        // Reset during vector 5 with NOR stuck at 1 (partial results nonzero)
        fault_nor1 = 1'b1;
        start_pulse(1'b0);
        for (int n = 1; n <= 10; n++) step();
        check_val("rst_pre_abc", o_abc, 5);
        check_val("rst_pre_err", o_err, 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_vals("midrst");
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("midrst_nodone", o_done, 0);
        end
        fault_nor1 = 1'b0;
        run_seq(1'b0, 1, 1'b0, 1'b1, 4'd0, 3'd0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
